// File: rtl/axi_burst_mem_slave_pkg.sv
// rtl/axi_burst_mem_slave_pkg.sv - shared FSM states and response codes
package axi_burst_mem_slave_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// rtl/axi_burst_mem_slave_if.sv - AXI-like burst bus with master/slave views
interface axi_burst_mem_slave_if #(
  parameter int ADDR_W = 40,
  parameter int ID_W   = 16,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic [ID_W-1:0]     bid;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic [ID_W-1:0]     rid;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awid, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arid, arlen, arvalid, rready,
    output awready, wready, bresp, bid, bvalid, arready, rdata, rresp, rid, rlast, rvalid
  );

  modport master (
    output awaddr, awid, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arid, arlen, arvalid, rready,
    input  awready, wready, bresp, bid, bvalid, arready, rdata, rresp, rid, rlast, rvalid
  );
endinterface

// File: rtl/axi_bmem_bank.sv
// rtl/axi_bmem_bank.sv - byte-writable memory with registered read port
module axi_bmem_bank #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Separate process from the write so a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_burst_mem_slave.sv
// rtl/axi_burst_mem_slave.sv - INCR burst memory slave with independent read/write FSMs
module axi_burst_mem_slave
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int ADDR_W    = 40,
  parameter int ID_W      = 16,
  parameter int DATA_W    = 128,
  parameter int MEM_DEPTH = 256
) (
  input logic                  s_axi_aclk,
  input logic                  s_axi_areset,
  axi_burst_mem_slave_if.slave s_axi
);
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  // One spare bit keeps start index + 255 beats from wrapping back into range.
  localparam logic [IDX_W:0] DEPTH_IDX = (IDX_W + 1)'(MEM_DEPTH);
  localparam logic [IDX_W:0] IDX_ONE   = (IDX_W + 1)'(1);

  w_state_t w_state, w_next;
  logic [IDX_W:0]  w_idx;
  logic [7:0]      w_len, w_cnt;
  logic            w_err;
  logic [ID_W-1:0] w_id, bid_q;
  logic [1:0]      bresp_q;
  logic            aw_hs, w_hs, b_hs, w_last_beat, w_in_range, w_beat_err;

  r_state_t r_state, r_next;
  logic [IDX_W:0]    r_idx;
  logic [7:0]        r_len, r_cnt;
  logic [ID_W-1:0]   rid_q;
  logic              rlast_q, r_oor, r_in_range, ar_hs, r_hs;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] bank_rdata;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^{s_axi.awaddr[OFF_W-1:0], s_axi.araddr[OFF_W-1:0]};

  assign aw_hs       = s_axi.awvalid & s_axi.awready;
  assign w_hs        = s_axi.wvalid & s_axi.wready;
  assign b_hs        = s_axi.bvalid & s_axi.bready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_in_range  = (w_idx < DEPTH_IDX);
  assign w_beat_err  = !w_in_range || (s_axi.wlast != w_last_beat);

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = !s_axi_areset && (w_state == W_IDLE);
    s_axi.wready  = !s_axi_areset && (w_state == W_DATA);
    s_axi.bvalid  = !s_axi_areset && (w_state == W_RESP);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_id    <= '0;
      bid_q   <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        w_idx <= {1'b0, s_axi.awaddr[ADDR_W-1:OFF_W]};
        w_len <= s_axi.awlen;
        w_cnt <= 8'd0;
        w_err <= 1'b0;
        w_id  <= s_axi.awid;
      end
      if (w_hs) begin
        w_idx <= w_idx + IDX_ONE;
        w_cnt <= w_cnt + 8'd1;
        w_err <= w_err | w_beat_err;
        if (w_last_beat) begin
          bid_q   <= w_id;
          bresp_q <= resp_of(w_err | w_beat_err);
        end
      end
    end
  end

  assign s_axi.bid   = bid_q;
  assign s_axi.bresp = bresp_q;

  assign ar_hs      = s_axi.arvalid & s_axi.arready;
  assign r_hs       = s_axi.rvalid & s_axi.rready;
  assign r_in_range = (r_idx < DEPTH_IDX);

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_hs) r_next = rlast_q ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = !s_axi_areset && (r_state == R_IDLE);
    s_axi.rvalid  = !s_axi_areset && (r_state == R_DATA);
  end

  // Beat status is latched alongside the memory read so all R outputs change together.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      rid_q   <= '0;
      rlast_q <= 1'b0;
      r_oor   <= 1'b0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_idx <= {1'b0, s_axi.araddr[ADDR_W-1:OFF_W]};
        r_len <= s_axi.arlen;
        r_cnt <= 8'd0;
        rid_q <= s_axi.arid;
      end
      if (r_state == R_FETCH) begin
        r_oor   <= !r_in_range;
        rresp_q <= resp_of(!r_in_range);
        rlast_q <= (r_cnt == r_len);
      end
      if (r_hs) begin
        r_idx <= r_idx + IDX_ONE;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign s_axi.rid   = rid_q;
  assign s_axi.rlast = rlast_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rdata = r_oor ? '0 : bank_rdata;

  axi_bmem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_bank (
    .clk   (s_axi_aclk),
    .rst   (s_axi_areset),
    .we    (w_hs && w_in_range),
    .waddr (w_idx[MEM_AW-1:0]),
    .wdata (s_axi.wdata),
    .wstrb (s_axi.wstrb),
    .re    ((r_state == R_FETCH) && r_in_range),
    .raddr (r_idx[MEM_AW-1:0]),
    .rdata (bank_rdata)
  );
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb/tb_axi_burst_mem_slave.sv - randomized bench against a word-array reference model
module tb_axi_burst_mem_slave;
  import axi_burst_mem_slave_pkg::*;

  localparam int AW = 40;
  localparam int IW = 16;
  localparam int DW = 128;
  localparam int DEPTH = 256;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_burst_mem_slave_if #(.ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) bus ();

  axi_burst_mem_slave #(
    .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .MEM_DEPTH(DEPTH)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .s_axi        (bus)
  );

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wd [256];
  logic [SW-1:0] ws [256];
  logic [DW-1:0] last_rdata;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bus.bready = 1'b0;  bus.rready = 1'b0; bus.wlast = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_awready"}, bus.awready, 0);
    chk({tag, "_rst_wready"},  bus.wready, 0);
    chk({tag, "_rst_arready"}, bus.arready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_bvalid0"}, bus.bvalid, 0);
    chk({tag, "_rvalid0"}, bus.rvalid, 0);
    chk({tag, "_outs0"}, {bus.rdata ^ DW'(bus.rid), bus.rlast, bus.rresp, bus.bresp, bus.bid}, 0);
    chk({tag, "_idle_ready"}, {bus.awready, bus.arready}, 2'b11);
  endtask

  // lmode: 0 = wlast on final beat, 1 = wlast never, 2 = wlast on first beat only
  task automatic axi_write(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                           input int lmode, input int abort_at, input string tag);
    logic err;
    longint idx;
    int n;
    err = 1'b0;
    @(posedge clk); #1;
    bus.awaddr = addr; bus.awid = id; bus.awlen = len[7:0]; bus.awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
    if (!bus.awready) begin
      chk({tag, "_aw_timeout"}, 1, 0);
      bus.awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (b == abort_at) begin
        do_reset({tag, "_abort"});
        repeat (4) @(negedge clk);
        chk({tag, "_abort_no_bvalid"}, bus.bvalid, 0);
        return;
      end
      bus.wdata = wd[b]; bus.wstrb = ws[b];
      bus.wlast = (lmode == 0) ? (b == len) : (lmode == 1) ? 1'b0 : (b == 0);
      bus.wvalid = 1'b1;
      @(negedge clk);
      if (b == 0) chk({tag, "_wready_lat"}, bus.wready, 1);
      n = 0;
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      if (!bus.wready) begin
        chk({tag, "_w_timeout"}, 1, 0);
        bus.wvalid = 1'b0;
        return;
      end
      idx = longint'(addr >> 4) + b;
      if (idx < DEPTH) begin
        for (int k = 0; k < SW; k++)
          if (ws[b][k]) model[int'(idx)][k*8 +: 8] = wd[b][k*8 +: 8];
      end else begin
        err = 1'b1;
      end
      if (bus.wlast != (b == len)) err = 1'b1;
      @(posedge clk); #1;
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_bvalid"}, bus.bvalid, 1);
    chk({tag, "_bid"}, bus.bid, id);
    chk({tag, "_bresp"}, bus.bresp, err ? RESP_SLVERR : RESP_OKAY);
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                          input int stall, input string tag);
    longint idx;
    logic [DW-1:0] ed;
    logic [1:0] er;
    int n;
    @(posedge clk); #1;
    bus.araddr = addr; bus.arid = id; bus.arlen = len[7:0]; bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
    if (!bus.arready) begin
      chk({tag, "_ar_timeout"}, 1, 0);
      bus.arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      @(negedge clk);
      chk({tag, "_fetch_gap"}, bus.rvalid, 0);
      @(negedge clk);
      chk({tag, "_rvalid"}, bus.rvalid, 1);
      idx = longint'(addr >> 4) + b;
      ed = (idx < DEPTH) ? model[int'(idx)] : '0;
      er = (idx < DEPTH) ? RESP_OKAY : RESP_SLVERR;
      chk($sformatf("%s_rdata%0d", tag, b), bus.rdata, ed);
      chk($sformatf("%s_rresp%0d", tag, b), bus.rresp, er);
      chk({tag, "_rid"}, bus.rid, id);
      chk($sformatf("%s_rlast%0d", tag, b), bus.rlast, (b == len));
      last_rdata = bus.rdata;
      if (b == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk({tag, "_stall_hold"}, {bus.rvalid, bus.rlast, bus.rid, bus.rdata},
              {1'b1, (b == len), id, ed});
        end
      end
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_rd_idle"}, {bus.rvalid, bus.arready}, 2'b01);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    int w, ln;
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    last_rdata = '0;

    do_reset("init");

    // Fill the whole memory so every later read has a defined expectation.
    for (int i = 0; i < 256; i++) begin wd[i] = rand_word(); ws[i] = '1; end
    axi_write('0, 16'h0001, 255, 0, -1, "fill");

    for (int i = 0; i < 4; i++) begin wd[i] = rand_word(); ws[i] = '1; end
    axi_write(40'h0, 16'h0012, 3, 0, -1, "basic_wr");
    axi_read(40'h0, 16'h00a7, 3, 0, "basic_rd");

    wd[0] = '1; ws[0] = '1;
    axi_write(40'd80, 16'h0005, 0, 0, -1, "w5_ones");
    wd[0] = '0; ws[0] = 16'h0001;
    axi_write(40'd80, 16'h0006, 0, 0, -1, "w5_byte");
    axi_read(40'd80, 16'h0007, 0, 0, "w5_rd");
    chk("w5_literal", last_rdata, {{120{1'b1}}, 8'h00});

    wd[0] = rand_word(); wd[1] = rand_word(); ws[0] = '1; ws[1] = '1;
    axi_write(40'(DEPTH * 16 - 16), 16'h0abc, 1, 0, -1, "edge_wr");
    axi_read(40'(DEPTH * 16 - 16), 16'h0abd, 1, 0, "edge_rd");
    chk("edge_beat2_zero", last_rdata, '0);

    for (int i = 0; i < 3; i++) begin wd[i] = rand_word(); ws[i] = '1; end
    axi_write(40'd320, 16'h0101, 2, 1, -1, "nolast");
    for (int i = 0; i < 3; i++) begin wd[i] = rand_word(); ws[i] = '1; end
    axi_write(40'd400, 16'h0102, 2, 2, -1, "earlylast");
    axi_read(40'd320, 16'h0103, 7, 0, "lasterr_rd");

    for (int i = 0; i < 4; i++) begin wd[i] = rand_word(); ws[i] = 16'(i * 16'h1111 + 16'h00f0); end
    fork
      axi_read(40'h0, 16'h0201, 3, 5, "stall_rd");
      axi_write(40'd1600, 16'h0202, 3, 0, -1, "conc_wr");
    join
    axi_read(40'd1600, 16'h0203, 3, 0, "conc_rd");

    for (int i = 0; i < 4; i++) begin wd[i] = rand_word(); ws[i] = '1; end
    axi_write(40'd2000, 16'h0301, 3, 0, 2, "abort");
    for (int i = 0; i < 2; i++) begin wd[i] = rand_word(); ws[i] = '1; end
    axi_write(40'd2400, 16'h0302, 1, 0, -1, "post_abort_wr");
    axi_read(40'd2000, 16'h0303, 3, 0, "abort_rd");

    for (int it = 0; it < 10; it++) begin
      w  = $urandom_range(0, DEPTH - 1);
      ln = $urandom_range(0, 7);
      for (int i = 0; i <= ln; i++) begin wd[i] = rand_word(); ws[i] = SW'($urandom); end
      axi_write(40'(w * 16 + $urandom_range(0, 15)), IW'($urandom), ln, 0, -1, $sformatf("rnd_wr%0d", it));
      axi_read(40'(w * 16), IW'($urandom), ln, (it % 3 == 0) ? 2 : 0, $sformatf("rnd_rd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_burst_mem_slave.md
AXI_BURST_MEM_SLAVE -- requirements
Module: axi_burst_mem_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 40, byte address width.
REQ-002 The block SHALL have parameter ID_W, default 16, transaction ID width.
REQ-003 The block SHALL have parameter DATA_W, default 128, data width; strobe width is DATA_W/8.
REQ-004 The block SHALL have parameter MEM_DEPTH, default 256, memory depth in DATA_W words, power of two.
REQ-005 The block SHALL have one clock and a synchronous active-high reset, as listed below.
REQ-006 s_axi_aclk  in  1  clock; all logic on the rising edge.
REQ-007 s_axi_areset  in  1  synchronous active-high reset.
REQ-008 s_axi_awaddr  in  ADDR_W  write burst start byte address.
REQ-009 s_axi_awid  in  ID_W  write ID.
REQ-010 s_axi_awlen  in  8  write beats minus one.
REQ-011 s_axi_awvalid  in  1  write address valid.
REQ-012 s_axi_awready  out  1  write address ready.
REQ-013 s_axi_wdata  in  DATA_W  write data.
REQ-014 s_axi_wstrb  in  DATA_W/8  byte enables.
REQ-015 s_axi_wlast  in  1  last write beat.
REQ-016 s_axi_wvalid  in  1  write data valid.
REQ-017 s_axi_wready  out  1  write data ready.
REQ-018 s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
REQ-019 s_axi_bid  out  ID_W  captured awid.
REQ-020 s_axi_bvalid  out  1  response valid.
REQ-021 s_axi_bready  in  1  response ready.
REQ-022 s_axi_araddr  in  ADDR_W  read burst start byte address.
REQ-023 s_axi_arid  in  ID_W  read ID.
REQ-024 s_axi_arlen  in  8  read beats minus one.
REQ-025 s_axi_arvalid  in  1  read address valid.
REQ-026 s_axi_arready  out  1  read address ready.
REQ-027 s_axi_rdata  out  DATA_W  read data.
REQ-028 s_axi_rresp  out  2  per-beat read response: 00 OKAY, 10 SLVERR.
REQ-029 s_axi_rid  out  ID_W  captured arid.
REQ-030 s_axi_rlast  out  1  last read beat.
REQ-031 s_axi_rvalid  out  1  read data valid.
REQ-032 s_axi_rready  in  1  read data ready.

Function
REQ-033 All bursts SHALL be treated as INCR with full-width beats.
REQ-034 Word index SHALL be addr[ADDR_W-1 : log2(DATA_W/8)] and SHALL increment by 1 per beat.
REQ-035 A beat whose word index is >= MEM_DEPTH SHALL be out of range.
REQ-036 Out-of-range write beats SHALL be dropped and SHALL force bresp=10; out-of-range read beats SHALL return rdata=0 and rresp=10.
REQ-037 The write FSM SHALL use states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1).
- W_IDLE->W_DATA on the AW handshake; awid, address and awlen are captured.
- W_DATA->W_RESP on the (awlen+1)th W handshake.
- W_RESP->W_IDLE on bready.
REQ-038 Each W handshake SHALL write only the bytes enabled by wstrb.
REQ-039 wlast not asserted on the final beat, or asserted early, SHALL give bresp=10; the beat count alone SHALL end the burst.
REQ-040 The read FSM SHALL use states R_IDLE (arready=1), R_FETCH (memory read, outputs held) and R_DATA (rvalid=1, outputs stable until rready).
- R_IDLE->R_FETCH on the AR handshake.
- R_FETCH->R_DATA after one cycle.
- R_DATA->R_FETCH on an R handshake of a non-last beat; R_DATA->R_IDLE on an R handshake of the last beat.
REQ-041 Latency: AW handshake at cycle N gives wready at N+1; the last W handshake at M gives bvalid at M+1; AR handshake at N gives first rvalid at N+2; throughput is one read beat per 2 cycles.
REQ-042 The read and write FSMs SHALL run concurrently; a read of a word written in the same cycle SHALL return the old data.

Reset
REQ-043 Reset SHALL return both FSMs to IDLE, force awready=wready=arready=0 for the reset cycle, and clear bvalid, rvalid, rlast, bresp, rresp, bid, rid and rdata to 0; memory contents SHALL be preserved; reset mid-burst SHALL abandon the burst with no response.

Structure
REQ-044 The shared package SHALL hold the FSM state enums and the RESP_OKAY/RESP_SLVERR constants.
REQ-045 The memory SHALL be one sub-module, axi_bmem_bank: single clock, byte-write port plus registered read port.

Verification
REQ-046 AW addr 0x0, len 3, id 0x12, then 4 W beats with wstrb all-ones -> bid=0x12, bresp=00; AR of the same burst -> 4 beats with matching data, rlast on beat 4, rid equal to arid.
REQ-047 Write 0xFF..FF to word 5, then write with wstrb=0x0001 and data 0 -> readback of word 5 = 0xFF..FF00.
REQ-048 awaddr = MEM_DEPTH*16 - 16, len 1 -> beat 1 written, beat 2 dropped, bresp=10; read of the same range -> rresp 00 then 10, beat 2 rdata=0.
REQ-049 rready held low 5 cycles during R_DATA -> rdata, rid and rlast stable; a concurrent write burst completes with bvalid.
REQ-050 Reset asserted after W beat 2 of 4 -> no bvalid; a new AW is accepted after reset and memory beats 1-2 retain their data.
